// File: rtl/temporal_ngram_encoder_if.sv
// Stream interface for the temporal n-gram encoder: hypervector input and output handshakes.
// The master side is the environment (upstream source plus downstream sink); the slave side is the encoder.
interface temporal_ngram_encoder_if #(
    parameter int HV_DIM = 2000
);
    logic              hvin_valid;
    logic              hvin_ready;
    logic [HV_DIM-1:0] hvin;
    logic              hvout_valid;
    logic              hvout_ready;
    logic [HV_DIM-1:0] hvout;

    modport master (
        output hvin_valid,
        output hvin,
        output hvout_ready,
        input  hvin_ready,
        input  hvout_valid,
        input  hvout
    );

    modport slave (
        input  hvin_valid,
        input  hvin,
        input  hvout_ready,
        output hvin_ready,
        output hvout_valid,
        output hvout
    );
endinterface

// File: rtl/temporal_ngram_encoder.sv
// Temporal n-gram encoder: keeps the last MAX_NGRAM hypervectors, permutes older entries once per step,
// and emits the XOR-bind of the newest N entries once the history holds at least N of them.
module temporal_ngram_encoder #(
    parameter int HV_DIM    = 2000,
    parameter int MAX_NGRAM = 4,
    parameter int NLW       = $clog2(MAX_NGRAM + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [NLW-1:0]         cfg_ngram_len,
    input  logic                   cfg_rotate,
    temporal_ngram_encoder_if.slave bus,
    output logic                   primed
);

    localparam logic [NLW-1:0] MAX_N = NLW'(MAX_NGRAM);
    localparam logic [NLW-1:0] ONE_N = NLW'(1);

    typedef logic [HV_DIM-1:0] hv_t;

    hv_t            hist_q [MAX_NGRAM];
    hv_t            hist_d [MAX_NGRAM];
    hv_t            hist_new [MAX_NGRAM];
    logic [NLW-1:0] fill_q, fill_d;
    logic [NLW-1:0] n_q, n_d;
    logic           rot_q, rot_d;
    logic           valid_q, valid_d;
    hv_t            hvout_q, hvout_d;
    logic           primed_q, primed_d;

    hv_t            bind_hv;
    logic [NLW-1:0] fill_inc;
    logic [NLW-1:0] n_clamped;
    logic           hvin_ready;
    logic           fire_in;
    logic           fire_out;

    function automatic hv_t perm(input hv_t x, input logic rot);
        return rot ? {x[0], x[HV_DIM-1:1]} : {1'b0, x[HV_DIM-1:1]};
    endfunction

    assign hvin_ready      = ~clear & (~valid_q | bus.hvout_ready);
    assign fire_in         = bus.hvin_valid & hvin_ready;
    assign fire_out        = valid_q & bus.hvout_ready;

    assign bus.hvin_ready  = hvin_ready;
    assign bus.hvout_valid = valid_q;
    assign bus.hvout       = hvout_q;
    assign primed          = primed_q;

    assign fill_inc = (fill_q == MAX_N) ? fill_q : fill_q + ONE_N;

    always_comb begin
        n_clamped = cfg_ngram_len;
        if (cfg_ngram_len == '0) begin
            n_clamped = ONE_N;
        end else if (cfg_ngram_len > MAX_N) begin
            n_clamped = MAX_N;
        end
    end

    // Candidate history after accepting the current input; the oldest entry falls off the end.
    always_comb begin
        hist_new[0] = bus.hvin;
        for (int i = 1; i < MAX_NGRAM; i++) begin
            hist_new[i] = perm(hist_q[i-1], rot_q);
        end
    end

    always_comb begin
        bind_hv = '0;
        for (int i = 0; i < MAX_NGRAM; i++) begin
            if (i < int'(n_q)) begin
                bind_hv = bind_hv ^ hist_new[i];
            end
        end
    end

    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        n_d      = n_q;
        rot_d    = rot_q;
        valid_d  = valid_q;
        hvout_d  = hvout_q;
        primed_d = primed_q;
        if (clear) begin
            hist_d   = '{default: '0};
            fill_d   = '0;
            valid_d  = 1'b0;
            primed_d = 1'b0;
            n_d      = n_clamped;
            rot_d    = cfg_rotate;
        end else if (fire_in) begin
            hist_d   = hist_new;
            fill_d   = fill_inc;
            primed_d = (fill_inc >= n_q);
            if (fill_inc >= n_q) begin
                hvout_d = bind_hv;
                valid_d = 1'b1;
            end else if (fire_out) begin
                valid_d = 1'b0;
            end
        end else if (fire_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q   <= '{default: '0};
            fill_q   <= '0;
            n_q      <= MAX_N;
            rot_q    <= 1'b0;
            valid_q  <= 1'b0;
            hvout_q  <= '0;
            primed_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            n_q      <= n_d;
            rot_q    <= rot_d;
            valid_q  <= valid_d;
            hvout_q  <= hvout_d;
            primed_q <= primed_d;
        end
    end

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Bench for temporal_ngram_encoder: directed scenarios plus randomized traffic, scored against a
// queue-based reference that recomputes each n-gram from the raw accepted inputs.
module tb_temporal_ngram_encoder;

    localparam int HV   = 8;
    localparam int MAXN = 4;
    localparam int NLW  = $clog2(MAXN + 1);

    logic           clk;
    logic           rst;
    logic           clear;
    logic [NLW-1:0] cfg_ngram_len;
    logic           cfg_rotate;
    logic           primed;

    temporal_ngram_encoder_if #(.HV_DIM(HV)) bus ();

    temporal_ngram_encoder #(.HV_DIM(HV), .MAX_NGRAM(MAXN)) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .cfg_ngram_len (cfg_ngram_len),
        .cfg_rotate    (cfg_rotate),
        .bus           (bus),
        .primed        (primed)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [HV-1:0] m_hist[$];
    logic [HV-1:0] exp_q[$];
    int            m_n   = MAXN;
    bit            m_rot = 1'b0;

    logic [HV-1:0] held;
    bit            stable_chk = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // x permuted k times: right shift by k, or right rotate by k
    function automatic logic [HV-1:0] perm_k(input logic [HV-1:0] x, input int k, input bit rot);
        if (k == 0) return x;
        if (rot) return (x >> k) | (x << (HV - k));
        return x >> k;
    endfunction

    function automatic logic [HV-1:0] model_out();
        logic [HV-1:0] acc = '0;
        for (int j = 0; j < m_n; j++) begin
            acc ^= perm_k(m_hist[m_hist.size() - 1 - j], j, m_rot);
        end
        return acc;
    endfunction

    function automatic int clamp_n(input int v);
        if (v == 0) return 1;
        if (v > MAXN) return MAXN;
        return v;
    endfunction

    // Reference model: tracks accepted inputs and latched config, predicts outputs and primed.
    always @(negedge clk) begin
        if (rst) begin
            m_hist.delete();
            exp_q.delete();
            m_n   = MAXN;
            m_rot = 1'b0;
        end else begin
            chk("primed", {31'd0, primed}, {31'd0, (m_hist.size() >= m_n)});
            if (clear) begin
                m_hist.delete();
                m_n   = clamp_n(int'(cfg_ngram_len));
                m_rot = cfg_rotate;
            end else if (bus.hvin_valid && bus.hvin_ready) begin
                m_hist.push_back(bus.hvin);
                if (m_hist.size() > MAXN) void'(m_hist.pop_front());
                if (m_hist.size() >= m_n) exp_q.push_back(model_out());
            end
        end
    end

    // Monitor: scoreboard pop on each output transfer, handshake and stability checks.
    always @(negedge clk) begin
        if (rst) begin
            stable_chk = 1'b0;
        end else begin
            chk("hvin_ready", {31'd0, bus.hvin_ready},
                {31'd0, (~clear & (~bus.hvout_valid | bus.hvout_ready))});
            if (stable_chk && bus.hvout_valid) chk("hvout_stable", {24'd0, bus.hvout}, {24'd0, held});
            stable_chk = bus.hvout_valid && !bus.hvout_ready;
            held       = bus.hvout;
            if (bus.hvout_valid && bus.hvout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    chk("hvout", {24'd0, bus.hvout}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input int n, input bit r);
        bus.hvin_valid  = 1'b0;
        bus.hvout_ready = 1'b1;
        clear           = 1'b1;
        cfg_ngram_len   = NLW'(n);
        cfg_rotate      = r;
        tick();
        clear           = 1'b0;
        cfg_ngram_len   = '0;
        cfg_rotate      = 1'b0;
    endtask

    task automatic send(input logic [HV-1:0] d);
        bit done = 1'b0;
        bus.hvin_valid = 1'b1;
        bus.hvin       = d;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (bus.hvin_ready) begin
                tick();
                done = 1'b1;
            end
        end
        bus.hvin_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [HV-1:0] h;
        bit            fired;

        rst             = 1'b1;
        clear           = 1'b0;
        cfg_ngram_len   = '0;
        cfg_rotate      = 1'b0;
        bus.hvin_valid  = 1'b0;
        bus.hvin        = '0;
        bus.hvout_ready = 1'b1;
        #2;
        chk("rst_valid",  {31'd0, bus.hvout_valid}, 32'd0);
        chk("rst_hvout",  {24'd0, bus.hvout}, 32'd0);
        chk("rst_primed", {31'd0, primed}, 32'd0);
        tick();
        rst = 1'b0;

        // N=3 shift: FF,0F,F0 -> C8
        do_clear(3, 1'b0);
        send(8'hFF);
        send(8'h0F);
        chk("warmup_valid", {31'd0, bus.hvout_valid}, 32'd0);
        send(8'hF0);
        chk("n3_shift_valid", {31'd0, bus.hvout_valid}, 32'd1);
        chk("n3_shift_hvout", {24'd0, bus.hvout}, 32'h C8);
        chk("n3_primed", {31'd0, primed}, 32'd1);

        // N=3 rotate: same stimulus -> 88
        do_clear(3, 1'b1);
        send(8'hFF);
        send(8'h0F);
        send(8'hF0);
        chk("n3_rot_hvout", {24'd0, bus.hvout}, 32'h88);

        // Backpressure for 5 cycles with a pending input
        do_clear(3, 1'b0);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        bus.hvout_ready = 1'b0;
        bus.hvin_valid  = 1'b1;
        bus.hvin        = 8'h78;
        h = bus.hvout;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hvin_ready", {31'd0, bus.hvin_ready}, 32'd0);
            chk("bp_hvout", {24'd0, bus.hvout}, {24'd0, h});
            chk("bp_valid", {31'd0, bus.hvout_valid}, 32'd1);
        end
        bus.hvout_ready = 1'b1;
        send(8'h78);
        send(8'h9A);
        send(8'hBC);

        // Mid-stream clear to N=1
        do_clear(1, 1'b0);
        chk("clear_drops_valid", {31'd0, bus.hvout_valid}, 32'd0);
        send(8'h5A);
        chk("n1_first", {24'd0, bus.hvout}, 32'h5A);
        chk("n1_first_valid", {31'd0, bus.hvout_valid}, 32'd1);
        send(8'hA5);
        chk("n1_second", {24'd0, bus.hvout}, 32'hA5);

        // Length 0 behaves as 1
        do_clear(0, 1'b0);
        send(8'h3C);
        chk("n0_as_1_valid", {31'd0, bus.hvout_valid}, 32'd1);
        chk("n0_as_1_hvout", {24'd0, bus.hvout}, 32'h3C);

        // Length 7 clamps to 4
        do_clear(7, 1'b0);
        send(8'h81);
        send(8'h42);
        send(8'h24);
        chk("n7_warmup", {31'd0, bus.hvout_valid}, 32'd0);
        send(8'h18);
        chk("n7_valid", {31'd0, bus.hvout_valid}, 32'd1);
        chk("n7_hvout", {24'd0, bus.hvout}, {24'd0, 8'h18 ^ (8'h24 >> 1) ^ (8'h42 >> 2) ^ (8'h81 >> 3)});

        // Reset while output is stalled
        do_clear(2, 1'b1);
        send(8'hC3);
        send(8'h3C);
        bus.hvout_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.hvout_valid}, 32'd0);
        chk("arst_hvout", {24'd0, bus.hvout}, 32'd0);
        chk("arst_primed", {31'd0, primed}, 32'd0);
        tick();
        rst = 1'b0;
        bus.hvout_ready = 1'b1;
        send(8'h01);
        send(8'h80);
        send(8'hFF);
        chk("post_rst_warmup", {31'd0, bus.hvout_valid}, 32'd0);
        send(8'h0F);
        chk("post_rst_valid", {31'd0, bus.hvout_valid}, 32'd1);
        chk("post_rst_hvout", {24'd0, bus.hvout}, {24'd0, 8'h0F ^ (8'hFF >> 1) ^ (8'h80 >> 2) ^ (8'h01 >> 3)});

        // Randomized segments with random config and random backpressure
        for (int s = 0; s < 8; s++) begin
            do_clear(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            bus.hvin_valid = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                fired = bus.hvin_valid && bus.hvin_ready;
                tick();
                if (fired || !bus.hvin_valid) begin
                    bus.hvin_valid = 1'($urandom_range(0, 1));
                    bus.hvin       = HV'($urandom);
                end
                bus.hvout_ready = ($urandom_range(0, 3) != 0);
            end
        end

        bus.hvin_valid  = 1'b0;
        bus.hvout_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
